// File: rtl/seq_scan_arbiter.sv
// Four requesters share one serial "101" detector. The winner of a round-robin
// grant has its byte scanned MSB first; overlapping matches are counted
// (saturating at 3) and a one-cycle done pulse closes the job.
module seq_scan_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [31:0] din,
    output logic [3:0]  gnt,
    output logic        busy,
    output logic        sbit,
    output logic        match,
    output logic        done,
    output logic [1:0]  count,
    output logic [1:0]  owner
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    typedef enum logic [1:0] {
        DetS0,
        DetS1,
        DetS10
    } det_e;

    state_e      state_q, state_d;
    det_e        det_q, det_d;
    logic [7:0]  sreg_q, sreg_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [3:0]  gnt_q, gnt_d;
    logic        match_q, match_d;
    logic [1:0]  count_q, count_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  last_q, last_d;

    logic        win_valid;
    logic [1:0]  win_idx;
    logic [1:0]  cand;
    logic [7:0]  win_byte;
    logic        hit;

    // Round-robin pick: search last+1, last+2, last+3, last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int k = 1; k <= 4; k++) begin
            cand = last_q + 2'(k);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Byte lane of the winning requester.
    always_comb begin
        unique case (win_idx)
            2'd0:    win_byte = din[7:0];
            2'd1:    win_byte = din[15:8];
            2'd2:    win_byte = din[23:16];
            default: win_byte = din[31:24];
        endcase
    end

    // Controller and detector next-state logic.
    always_comb begin
        state_d  = state_q;
        det_d    = det_q;
        sreg_d   = sreg_q;
        bitcnt_d = bitcnt_q;
        gnt_d    = gnt_q;
        match_d  = 1'b0;
        count_d  = count_q;
        owner_d  = owner_q;
        last_d   = last_q;
        hit      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (win_valid) begin
                    gnt_d    = 4'(1) << win_idx;
                    owner_d  = win_idx;
                    last_d   = win_idx;
                    sreg_d   = win_byte;
                    bitcnt_d = 3'd0;
                    count_d  = 2'd0;
                    det_d    = DetS0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                // Mealy detector consumes the bit currently on sbit.
                unique case (det_q)
                    DetS0:   det_d = sreg_q[7] ? DetS1 : DetS0;
                    DetS1:   det_d = sreg_q[7] ? DetS1 : DetS10;
                    DetS10: begin
                        det_d = sreg_q[7] ? DetS1 : DetS0;
                        hit   = sreg_q[7];
                    end
                    default: det_d = DetS0;
                endcase
                match_d = hit;
                if (hit && count_q != 2'd3) begin
                    count_d = count_q + 2'd1;
                end
                sreg_d   = {sreg_q[6:0], 1'b0};
                bitcnt_d = bitcnt_q + 3'd1;
                if (bitcnt_q == 3'd7) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                gnt_d   = 4'd0;
                state_d = StIdle;
            end
            default: begin
                gnt_d   = 4'd0;
                state_d = StIdle;
            end
        endcase
    end

    // State registers; reset leaves requester 0 with first priority.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            det_q    <= DetS0;
            sreg_q   <= 8'd0;
            bitcnt_q <= 3'd0;
            gnt_q    <= 4'd0;
            match_q  <= 1'b0;
            count_q  <= 2'd0;
            owner_q  <= 2'd0;
            last_q   <= 2'd3;
        end else begin
            state_q  <= state_d;
            det_q    <= det_d;
            sreg_q   <= sreg_d;
            bitcnt_q <= bitcnt_d;
            gnt_q    <= gnt_d;
            match_q  <= match_d;
            count_q  <= count_d;
            owner_q  <= owner_d;
            last_q   <= last_d;
        end
    end

    // Outputs decoded from registered state.
    always_comb begin
        gnt   = gnt_q;
        busy  = (state_q != StIdle);
        sbit  = (state_q == StShift) & sreg_q[7];
        match = match_q;
        done  = (state_q == StDone);
        count = count_q;
        owner = owner_q;
    end

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Bench for seq_scan_arbiter: a reference model predicts the winner, the
// per-bit match pulses and the final count; job results go through a queue.
module tb_seq_scan_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [31:0] din;
    logic [3:0]  gnt;
    logic        busy;
    logic        sbit;
    logic        match;
    logic        done;
    logic [1:0]  count;
    logic [1:0]  owner;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0] owner;
        logic [1:0] count;
    } exp_t;

    exp_t       sb[$];
    logic [1:0] m_last;
    logic [1:0] m_owner;
    logic [1:0] m_count;

    seq_scan_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .din   (din),
        .gnt   (gnt),
        .busy  (busy),
        .sbit  (sbit),
        .match (match),
        .done  (done),
        .count (count),
        .owner (owner)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    // flags[k] = 1 when the k-th consumed bit (k = 1..8) ends a 101 in the stream.
    function automatic logic [8:0] model_flags(input logic [7:0] b);
        logic [8:0] f;
        logic [8:0] s;
        f = 9'd0;
        s = 9'd0;
        for (int k = 1; k <= 8; k++) s[k] = b[8-k];
        for (int k = 3; k <= 8; k++) f[k] = s[k-2] & ~s[k-1] & s[k];
        return f;
    endfunction

    function automatic logic [1:0] model_count(input logic [8:0] f);
        int n;
        n = 0;
        for (int k = 0; k <= 8; k++) n += int'(f[k]);
        return (n > 3) ? 2'd3 : 2'(n);
    endfunction

    function automatic logic [1:0] model_pick(input logic [3:0] r, input logic [1:0] last);
        logic [1:0] idx;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (r[idx]) return idx;
        end
        return last;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full job from IDLE; returns after E9. Optional request drop and din change.
    task automatic run_job(input logic [3:0] r, input logic [31:0] d, input int drop_at,
                           input int newdin_at, input logic [31:0] d2);
        logic [1:0] w;
        logic [7:0] b;
        logic [8:0] fl;
        logic [1:0] run;
        logic [1:0] ecnt;
        exp_t       e;
        exp_t       got;
        req  = r;
        din  = d;
        w    = model_pick(r, m_last);
        b    = d[w*8 +: 8];
        fl   = model_flags(b);
        ecnt = model_count(fl);
        m_last = w;
        e.owner = w;
        e.count = ecnt;
        sb.push_back(e);
        step();
        checks++;
        if (gnt !== (4'(1) << w)) begin
            errors++;
            $display("FAIL gnt_e0: got %b required %b", gnt, 4'(1) << w);
        end
        checks++;
        if (owner !== w) begin
            errors++;
            $display("FAIL owner_e0: got %0d required %0d", owner, w);
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL busy_done_e0: got busy=%b done=%b required 1 0", busy, done);
        end
        checks++;
        if (sbit !== b[7]) begin
            errors++;
            $display("FAIL sbit_e0: got %b required %b", sbit, b[7]);
        end
        run = 2'd0;
        for (int k = 1; k <= 8; k++) begin
            if (k - 1 == drop_at) req = 4'd0;
            if (k - 1 == newdin_at) din = d2;
            step();
            if (fl[k] && run != 2'd3) run = run + 2'd1;
            checks++;
            if (match !== fl[k]) begin
                errors++;
                $display("FAIL match_e%0d: got %b required %b", k, match, fl[k]);
            end
            checks++;
            if (count !== run) begin
                errors++;
                $display("FAIL count_e%0d: got %0d required %0d", k, count, run);
            end
            if (k < 8) begin
                checks++;
                if (sbit !== b[7-k] || done !== 1'b0) begin
                    errors++;
                    $display("FAIL sbit_e%0d: got sbit=%b done=%b required %b 0",
                             k, sbit, done, b[7-k]);
                end
            end
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || gnt !== (4'(1) << w) || sbit !== 1'b0) begin
            errors++;
            $display("FAIL done_e8: got done=%b busy=%b gnt=%b sbit=%b required 1 1 %b 0",
                     done, busy, gnt, sbit, 4'(1) << w);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL scoreboard: got empty queue required one entry");
        end else begin
            got = sb.pop_front();
            if (count !== got.count || owner !== got.owner) begin
                errors++;
                $display("FAIL job_result: got count=%0d owner=%0d required %0d %0d",
                         count, owner, got.count, got.owner);
            end
        end
        step();
        checks++;
        if (gnt !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || match !== 1'b0) begin
            errors++;
            $display("FAIL idle_e9: got gnt=%b busy=%b done=%b match=%b required 0",
                     gnt, busy, done, match);
        end
        checks++;
        if (count !== ecnt || owner !== w) begin
            errors++;
            $display("FAIL hold_e9: got count=%0d owner=%0d required %0d %0d",
                     count, owner, ecnt, w);
        end
        m_owner = w;
        m_count = ecnt;
    endtask

    task automatic check_all_zero(input string name);
        checks++;
        if (gnt !== 4'd0 || busy !== 1'b0 || sbit !== 1'b0 || match !== 1'b0 ||
            done !== 1'b0 || count !== 2'd0 || owner !== 2'd0) begin
            errors++;
            $display("FAIL %s: got gnt=%b busy=%b sbit=%b match=%b done=%b count=%0d owner=%0d required all 0",
                     name, gnt, busy, sbit, match, done, count, owner);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        check_all_zero("reset_async");
        m_last  = 2'd3;
        m_owner = 2'd0;
        m_count = 2'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        req   = 4'd0;
        din   = 32'd0;
        do_reset();
        step();
        check_all_zero("reset_first_edge");
    endtask

    task automatic test_alternating();
        run_job(4'b0001, 32'h0000_00AA, -1, -1, 32'd0);
    endtask

    task automatic test_two_and_zero();
        run_job(4'b0100, 32'h00DB_0000, -1, -1, 32'd0);
        run_job(4'b0100, 32'hFF00_FFFF, -1, -1, 32'd0);
        run_job(4'b1000, 32'hB5FF_FFFF, -1, -1, 32'd0);
    endtask

    task automatic test_idle_stable();
        req = 4'd0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if (gnt !== 4'd0 || busy !== 1'b0 || done !== 1'b0 || sbit !== 1'b0 ||
                match !== 1'b0 || count !== m_count || owner !== m_owner) begin
                errors++;
                $display("FAIL idle_stable: got gnt=%b busy=%b count=%0d owner=%0d required 0 0 %0d %0d",
                         gnt, busy, count, owner, m_count, m_owner);
            end
        end
    endtask

    task automatic test_round_robin();
        req = 4'd0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_job(4'b1111, $urandom, -1, -1, 32'd0);
        end
    endtask

    task automatic test_back_to_back();
        // A requester other than the last owner must win before the last owner repeats.
        run_job(4'b1010, 32'h5A5A_5A5A, -1, -1, 32'd0);
        run_job(4'b1010, 32'hA5A5_A5A5, -1, -1, 32'd0);
        run_job(4'b1010, 32'h1234_5678, -1, -1, 32'd0);
    endtask

    task automatic test_drop_req();
        run_job(4'b0010, 32'h0000_A500, 2, -1, 32'd0);
    endtask

    task automatic test_din_change();
        run_job(4'b0001, 32'hFFFF_FF2D, -1, 1, 32'h0000_00D2);
        run_job(4'b0001, 32'h0000_0000, -1, 3, 32'hFFFF_FFAA);
    endtask

    task automatic test_mid_reset();
        req = 4'b0010;
        din = 32'h0000_AA00;
        m_last = model_pick(req, m_last);
        for (int i = 0; i < 5; i++) step();
        req = 4'd0;
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("reset_mid_job");
        m_last  = 2'd3;
        m_owner = 2'd0;
        m_count = 2'd0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0 || gnt !== 4'd0) begin
                errors++;
                $display("FAIL no_done_after_abort: got done=%b busy=%b gnt=%b required 0",
                         done, busy, gnt);
            end
        end
        run_job(4'b1111, 32'h0505_0505, -1, -1, 32'd0);
    endtask

    initial begin
        reset  = 1'b0;
        req    = 4'd0;
        din    = 32'd0;
        m_last = 2'd3;
        m_owner = 2'd0;
        m_count = 2'd0;
        test_reset();
        test_alternating();
        test_two_and_zero();
        test_idle_stable();
        test_round_robin();
        test_back_to_back();
        test_drop_req();
        test_din_change();
        test_mid_reset();
        test_idle_stable();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_scan_arbiter.md
SEQ_SCAN_ARBITER -- requirements
Module: seq_scan_arbiter

Interface
REQ-001 The module SHALL have a single clock domain and an asynchronous, active-high reset; every other port SHALL be synchronous to clk.
REQ-002 Port list (name, direction, width, meaning):
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: asynchronous active-high reset.
- req, input, 4: request, one bit per requester 0..3.
- din, input, 32: requester words; requester i drives din[8i+7:8i].
- gnt, output, 4: one-hot grant, held for the whole job.
- busy, output, 1: high while a job is in SHIFT or DONE.
- sbit, output, 1: bit currently presented to the detector; sreg[7] in SHIFT, otherwise 0.
- match, output, 1: registered one-cycle pulse for each detected 101.
- done, output, 1: one-cycle pulse marking job completion.
- count, output, 2: number of 101 matches in the last job (0..3).
- owner, output, 2: index of the current or last granted requester.

Function
REQ-003 The block SHALL share one internal serial 101 detector among four requesters, and SHALL scan one 8-bit word per grant, MSB first.
REQ-004 The controller FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-005 In IDLE, a rising edge with req != 0 SHALL do all of the following:
- select the winner by round robin;
- set gnt to that requester's one-hot value and set owner to its index;
- load sreg with the winner's din byte;
- clear the bit counter, count and the detector state;
- go to SHIFT.
REQ-006 Round-robin arbitration SHALL use priority order last+1, last+2, last+3, last (mod 4), where last is the previous owner.
- The pointer SHALL update at each grant.
REQ-007 In SHIFT, each rising edge SHALL consume sbit into the detector, shift sreg left by one and increment the bit counter.
- The edge that consumes bit 7 (counter = 7) SHALL move the FSM to DONE.
REQ-008 The detector SHALL be a Mealy machine with states S0 (nothing seen), S1 (seen 1) and S10 (seen 10). Transitions:
- S0: input 1 to S1, input 0 to S0.
- S1: input 1 to S1, input 0 to S10.
- S10: input 1 to S1 and a match is flagged; input 0 to S0.
REQ-009 Matches SHALL overlap: for example, 10101 yields 2.
REQ-010 Each flagged match SHALL set match = 1 for the following cycle and increment count.
- count saturates at 3.
- An 8-bit word cannot exceed 3 matches.
REQ-011 DONE SHALL last exactly one cycle, then return to IDLE.
- During DONE: done = 1, count is final, and gnt and busy are still asserted.
- On the next edge: gnt = 0, busy = 0, done = 0.
REQ-012 Latency: the grant edge is E0.
- Bits are consumed on edges E1..E8.
- done is high between E8 and E9.
- The earliest next grant is at E10, because IDLE lasts at least one cycle.
REQ-013 req and din SHALL be sampled only at the grant edge.
- Changes to req or din during SHIFT or DONE SHALL be ignored.
- A dropped request SHALL still complete its job and pulse done.
REQ-014 count and owner SHALL hold their values through IDLE until the next grant.
REQ-015 With req = 0 in IDLE, the block SHALL stay in IDLE with all outputs stable.

Reset
REQ-016 Asserting reset SHALL immediately, without waiting for clk, force:
- FSM to IDLE and detector to S0;
- gnt = 0, busy = 0, sbit = 0, match = 0, done = 0, count = 0, owner = 0;
- round-robin pointer last = 3, so requester 0 has first priority.
REQ-017 Reset asserted mid-job SHALL abort the job with no done pulse.
REQ-018 After reset deasserts, the first rising edge SHALL behave as IDLE.

Verification
REQ-019 req = 0001, din[7:0] = 8'b10101010 -> gnt = 0001 from E0; match pulses after E3, E5 and E7; done at E8; count = 3.
REQ-020 req = 0100, din[23:16] = 8'b11011011 -> count = 2, owner = 2; din = 8'h00 -> count = 0, no match pulses.
REQ-021 req = 1111 held constantly after reset -> grants 0, 1, 2, 3, 0 in order, consecutive grant edges 10 cycles apart.
REQ-022 req = 0010 deasserted after E2 -> job completes; done pulses at E8; gnt drops after E9.
REQ-023 reset asserted between E4 and E5 -> all outputs 0 immediately, no done pulse; the next grant goes to requester 0 if requested.
REQ-024 din changed mid-SHIFT -> the sbit sequence and count reflect only the byte latched at E0.
